uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single TX byte stream of the UART wrapper between N_REQ message-oriented requesters, e.g. a debug console, a telemetry streamer and a command responder. It grants one requester per message, optionally prefixes the message with a channel-ID header byte, and forwards the payload bytes unmodified until the requester's last byte. A message-level idle watchdog releases a requester that stalls mid-message, so the UART can never be locked.

## Interface
- N_REQ, 4, number of requesters (2..8)
- HDR_EN, 1, 1 = emit header byte before each message; 0 = no header
- HDR_BASE, 8'hF0, header byte value = HDR_BASE + granted index (8-bit wrap)
- TIMEOUT, 1024, idle cycles tolerated mid-message before forced release; 0 disables watchdog
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_data  in  8*N_REQ  requester i byte at [8i+7:8i]
- req_valid  in  N_REQ  requester byte valid
- req_last  in  N_REQ  byte is last of message
- req_ready  out  N_REQ  byte accepted when valid & ready
- tx_data  out  8  to uart_wrapper tx_data
- tx_valid  out  1  to uart_wrapper tx_valid
- tx_ready  in  1  from uart_wrapper tx_ready
- grant  out  N_REQ  one-hot current owner, all-zero in IDLE
- busy  out  1  high whenever state != IDLE
- timeout_pulse  out  1  one-cycle pulse on watchdog release
- timeout_id  out  $clog2(N_REQ)  index released by last watchdog event

## Operation
- States: IDLE, HEADER, PAYLOAD.
- IDLE: if any req_valid is set, select the first set bit searching from last_id+1 upward with wrap. Register sel and grant, then go to HEADER (HDR_EN=1) or PAYLOAD (HDR_EN=0). If no req_valid is set, stay in IDLE.
- HEADER: tx_valid=1, tx_data=HDR_BASE+sel, and all req_ready are 0. On tx_ready go to PAYLOAD.
- PAYLOAD: combinational pass-through from the granted requester only. tx_data=req_data[sel], tx_valid=req_valid[sel], req_ready[sel]=tx_ready. All other req_ready are 0.
- End of message: a handshake with req_last[sel]=1 moves the arbiter to IDLE and sets last_id=sel.
- Watchdog: the counter clears on entry to PAYLOAD and on every payload handshake. It increments on each PAYLOAD cycle with req_valid[sel]=0. When it reaches TIMEOUT (TIMEOUT>0), the arbiter goes to IDLE, sets last_id=sel, pulses timeout_pulse, and loads timeout_id=sel. Remaining bytes of that message arrive later as a new message.
- The selected requester stays granted even if it drops req_valid after selection; the header is still sent.
- Single-byte message (last on first byte) is legal.
- No requester may keep another starved: fairness is per message.

## Timing
- Reset values: state IDLE, grant 0, busy 0, tx_valid 0, tx_data 0, req_ready 0, timeout_pulse 0, timeout_id 0, counter 0, last_id N_REQ-1 (requester 0 wins first).
- Reset is asynchronous at any point, including mid-header or mid-payload. Outputs go to reset values immediately and no partial state survives.
- Arbitration latency: req_valid seen in IDLE at cycle t gives HEADER (or PAYLOAD) at t+1.
- At least one IDLE cycle separates consecutive messages. A requester asserting valid during IDLE is considered in that same cycle.
- Header is held on tx_valid until tx_ready; tx_data stays stable while tx_valid=1 and tx_ready=0.
- Payload adds zero latency. Requesters must hold data/valid stable until ready, per the codebase valid/ready rule.
- Watchdog release occurs at the cycle the counter equals TIMEOUT. The FSM is in IDLE the next cycle, with timeout_pulse high for exactly that cycle.
- A handshake in the same cycle the counter would reach TIMEOUT takes precedence: no release.

## Test plan
- Single requester: req 2 sends 3 bytes 0x11,0x22,0x33(last), tx_ready=1 → tx sees 0xF2,0x11,0x22,0x33; grant=4'b0100 for 4 cycles, then IDLE.
- Round robin: all 4 requesters send 1-byte messages continuously → grant order 0,1,2,3,0; each message preceded by its header 0xF0..0xF3.
- Backpressure: tx_ready toggles 1010… during header and payload → no byte lost or duplicated; tx_data stable while stalled; req_ready only on the granted line.
- Watchdog: TIMEOUT=8; req 1 sends one non-last byte then drops valid → after 8 idle cycles timeout_pulse=1, timeout_id=1; req 3 then granted next.
- HDR_EN=0: req 0 sends 0xAA(last) → tx sees only 0xAA, one cycle after arbitration.
- Reset mid-payload: assert reset_n=0 during req 1 byte 2 → grant, busy, tx_valid drop to 0 asynchronously; after release requester 0 has priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter sharing the UART TX byte stream
//
// Purpose:
//   Grants the single UART TX byte stream to one of N_REQ requesters per
//   message. Optionally sends a channel-ID header byte (HDR_BASE + index)
//   before the payload, then passes the owner's bytes through combinationally
//   until its last byte. A watchdog frees the stream if the owner stalls
//   mid-message for TIMEOUT cycles.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   req_data            requester i byte at [8i+7:8i]
//   req_valid/req_last  per-requester byte valid / last byte of message
//   req_ready           per-requester accept (only the owner's line can rise)
//   tx_data/tx_valid    byte stream towards the UART wrapper
//   tx_ready            UART wrapper accepts the current byte
//   grant               one-hot current owner, zero while idle
//   busy                arbiter is inside a message (header or payload)
//   timeout_pulse       one-cycle pulse after a watchdog release
//   timeout_id          index released by the most recent watchdog event

module uart_tx_arbiter #(
  parameter int         N_REQ    = 4,
  parameter bit         HDR_EN   = 1'b1,
  parameter logic [7:0] HDR_BASE = 8'hF0,
  parameter int         TIMEOUT  = 1024,
  localparam int        IDW      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 timeout_pulse,
  output logic [IDW-1:0]       timeout_id
);

  // Counter wide enough to hold TIMEOUT; a disabled watchdog keeps one bit.
  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            WD_ON   = (TIMEOUT > 0);
  localparam logic [CW-1:0] WD_LAST = WD_ON ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [IDW-1:0] sel;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] rr_cand;
  logic           pick_found;
  logic [N_REQ-1:0] grant_pick;

  logic [CW-1:0]  wd_cnt;

  logic [7:0]     sel_data;
  logic           sel_valid;
  logic           sel_last;
  logic           pay_hs;
  logic           msg_end;
  logic           wd_fire;

  // Owner's lane, selected by the registered index.
  assign sel_data  = req_data[{sel, 3'b000} +: 8];
  assign sel_valid = req_valid[sel];
  assign sel_last  = req_last[sel];

  assign pay_hs  = (state == ST_PAYLOAD) && sel_valid && tx_ready;
  assign msg_end = pay_hs && sel_last;

  // Release happens in the cycle the idle count reaches TIMEOUT. A present
  // byte (valid) never counts as idle, so a handshake always wins.
  assign wd_fire = WD_ON && (state == ST_PAYLOAD) && !sel_valid && (wd_cnt == WD_LAST);

  // Round-robin search: first requesting index after last_id, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_cand = IDW'((int'(last_id) + k) % N_REQ);
      if (!pick_found && req_valid[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  assign grant_pick = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = HDR_EN ? ST_HEADER : ST_PAYLOAD;
        end
      end
      ST_HEADER: begin
        if (tx_ready) begin
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (msg_end || wd_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: header is generated locally, payload is a pure pass-through.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state)
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BASE + {{(8-IDW){1'b0}}, sel};
      end
      ST_PAYLOAD: begin
        tx_valid       = sel_valid;
        tx_data        = sel_data;
        req_ready[sel] = tx_ready;
      end
      default: begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Ownership bookkeeping. The owner is latched at selection and kept even if
  // it drops valid afterwards; last_id moves only when a message ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel     <= '0;
      grant   <= '0;
      last_id <= IDW'(N_REQ - 1);
    end else begin
      if ((state == ST_IDLE) && pick_found) begin
        sel   <= pick_idx;
        grant <= grant_pick;
      end else if (msg_end || wd_fire) begin
        grant <= '0;
      end
      if (msg_end || wd_fire) begin
        last_id <= sel;
      end
    end
  end

  // Watchdog: held at zero outside PAYLOAD (so entry starts from zero),
  // cleared by every payload byte, counts owner-idle cycles otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt        <= '0;
      timeout_pulse <= 1'b0;
      timeout_id    <= '0;
    end else begin
      if ((state != ST_PAYLOAD) || pay_hs || wd_fire) begin
        wd_cnt <= '0;
      end else if (!sel_valid && WD_ON) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      timeout_pulse <= wd_fire;
      if (wd_fire) begin
        timeout_id <= sel;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int         N  = 4;
  localparam int         TO = 8;
  localparam logic [7:0] HB = 8'hF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [3:0]  grant;
  logic        busy, timeout_pulse;
  logic [1:0]  timeout_id;

  logic [31:0] req_data_b;
  logic [3:0]  req_valid_b, req_last_b, req_ready_b;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b, tx_ready_b;
  logic [3:0]  grant_b;
  logic        busy_b, timeout_pulse_b;
  logic [1:0]  timeout_id_b;

  uart_tx_arbiter #(.N_REQ(N), .HDR_EN(1'b1), .HDR_BASE(HB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse),
    .timeout_id(timeout_id)
  );

  uart_tx_arbiter #(.N_REQ(N), .HDR_EN(1'b0), .HDR_BASE(HB), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_data(req_data_b), .req_valid(req_valid_b),
    .req_last(req_last_b), .req_ready(req_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .grant(grant_b), .busy(busy_b), .timeout_pulse(timeout_pulse_b),
    .timeout_id(timeout_id_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side message queues (what each requester still has to send).
  logic [7:0] q_data [N][$];
  bit         q_last [N][$];
  int         gap_wait [N];
  bit         accepted [N];
  bit         gen_en;
  int         ready_mode;
  int         gap_override;
  int         gen_bytes, tx_count, n_wd;
  logic [7:0] txlog [$];

  // Reference model: who owns the stream and which part of the message is due.
  int m_owner, m_phase, m_last, m_gap, m_tid, m_grants;
  bit m_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_phase = 0; m_last = N - 1; m_gap = 0; m_tid = 0; m_pulse = 0;
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input bit l);
    q_data[i].push_back(d);
    q_last[i].push_back(l);
    gen_bytes++;
  endtask

  task automatic push_msg(input int i, input int len);
    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q_data[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_gap(input bit was_last);
    int r;
    if (was_last) return $urandom_range(0, 3);
    if (gap_override >= 0) return gap_override;
    r = $urandom_range(0, 15);
    if (r == 0) return 12;
    if (r < 4) return r;
    return 0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (accepted[i]) begin
        req_valid[i] = 1'b0;
        accepted[i]  = 1'b0;
      end
      if (!req_valid[i]) begin
        if (gap_wait[i] > 0) gap_wait[i]--;
        else if (q_data[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = q_data[i][0];
          req_last[i]        = q_last[i][0];
        end else if (gen_en && $urandom_range(0, 5) == 0) begin
          push_msg(i, $urandom_range(1, 4));
        end
      end
    end
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      default: tx_ready = ~tx_ready;
    endcase
  endtask

  task automatic compare_outputs();
    logic [3:0] e_grant, e_ready;
    logic       e_valid;
    e_grant = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    e_valid = (m_phase == 1) ? 1'b1 : (m_phase == 2) ? req_valid[m_owner] : 1'b0;
    e_ready = (m_phase == 2 && tx_ready) ? 4'(1 << m_owner) : 4'b0;
    check("grant", grant, e_grant);
    check("busy", busy, m_owner >= 0);
    check("tx_valid", tx_valid, e_valid);
    if (m_phase == 0) check("tx_data_idle", tx_data, 8'h00);
    else if (m_phase == 1) check("tx_data_hdr", tx_data, 8'(HB + m_owner));
    else if (req_valid[m_owner]) check("tx_data_pay", tx_data, q_data[m_owner][0]);
    check("req_ready", req_ready, e_ready);
    check("timeout_pulse", timeout_pulse, m_pulse);
    check("timeout_id", timeout_id, m_tid);
  endtask

  task automatic update();
    bit was_last;
    if (tx_valid && tx_ready) begin
      tx_count++;
      txlog.push_back(tx_data);
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] && q_data[i].size() > 0) begin
        accepted[i] = 1'b1;
        was_last    = q_last[i][0];
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
        gap_wait[i] = next_gap(was_last);
      end
    end
    m_pulse = 0;
    case (m_phase)
      0: if (req_valid != 4'b0) begin
        for (int k = 1; k <= N; k++)
          if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
        m_phase = 1;
        m_grants++;
      end
      1: if (tx_ready) begin
        m_phase = 2;
        m_gap   = 0;
      end
      default: begin
        if (req_valid[m_owner] && tx_ready) begin
          m_gap = 0;
          if (req_last[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_phase = 0;
          end
        end else if (!req_valid[m_owner]) begin
          m_gap++;
          if (m_gap == TO) begin
            m_pulse = 1; m_tid = m_owner; n_wd++;
            m_last = m_owner; m_owner = -1; m_phase = 0;
          end
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_inputs();
    #1;
    compare_outputs();
    update();
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      cycle();
      n++;
      done = (m_phase == 0) && queues_empty();
    end
    cycle();
    check(tag, done, 1'b1);
  endtask

  task automatic check_log(input string tag, input logic [7:0] exp [$]);
    check({tag, "_len"}, txlog.size(), exp.size());
    for (int k = 0; k < exp.size() && k < txlog.size(); k++)
      check($sformatf("%s_%0d", tag, k), txlog[k], exp[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_log [$];
    int n;

    reset_n = 1'b0;
    req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
    req_data_b = '0; req_valid_b = '0; req_last_b = '0; tx_ready_b = 1'b0;
    gen_en = 0; ready_mode = 0; gap_override = 0;
    gen_bytes = 0; tx_count = 0; n_wd = 0; m_grants = 0;
    for (int i = 0; i < N; i++) begin gap_wait[i] = 0; accepted[i] = 0; end
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", grant, 4'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_req_ready", req_ready, 4'b0);
    check("rst_pulse", timeout_pulse, 1'b0);
    check("rst_tid", timeout_id, 2'd0);
    check("rst_b_busy", busy_b, 1'b0);
    reset_n = 1'b1;

    // No header: payload appears one cycle after arbitration.
    @(negedge clk);
    req_valid_b = 4'b0001; req_data_b = 32'h0000_00AA; req_last_b = 4'b0001; tx_ready_b = 1'b1;
    #1;
    check("b_idle_busy", busy_b, 1'b0);
    check("b_idle_valid", tx_valid_b, 1'b0);
    @(negedge clk); #1;
    check("b_tx_valid", tx_valid_b, 1'b1);
    check("b_tx_data", tx_data_b, 8'hAA);
    check("b_grant", grant_b, 4'b0001);
    check("b_req_ready", req_ready_b, 4'b0001);
    @(negedge clk);
    req_valid_b = 4'b0; tx_ready_b = 1'b0;
    #1;
    check("b_end_busy", busy_b, 1'b0);
    check("b_end_valid", tx_valid_b, 1'b0);

    // Round robin: every requester has two single-byte messages.
    txlog.delete(); exp_log.delete();
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 2; r++) push_byte(i, 8'(16 * i + r + 1), 1'b1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        exp_log.push_back(8'(HB + i));
        exp_log.push_back(8'(16 * i + r + 1));
      end
    run_until_idle("rr_drain", 200);
    check_log("rr_seq", exp_log);

    // Single requester, three bytes.
    txlog.delete();
    push_byte(2, 8'h11, 0); push_byte(2, 8'h22, 0); push_byte(2, 8'h33, 1);
    run_until_idle("single_drain", 100);
    exp_log = '{8'hF2, 8'h11, 8'h22, 8'h33};
    check_log("single_seq", exp_log);

    // Backpressure with alternating tx_ready; last owner was 2, so 3 goes first.
    txlog.delete();
    ready_mode = 2;
    push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 1);
    push_byte(3, 8'h31, 0); push_byte(3, 8'h32, 0); push_byte(3, 8'h33, 1);
    run_until_idle("bp_drain", 200);
    exp_log = '{8'hF3, 8'h31, 8'h32, 8'h33, 8'hF0, 8'h01, 8'h02};
    check_log("bp_seq", exp_log);

    // Randomized traffic including long stalls that trip the watchdog.
    gap_override = -1;
    gen_en = 1;
    ready_mode = 1;
    repeat (1500) cycle();
    ready_mode = 2;
    repeat (1500) cycle();
    gen_en = 0;
    ready_mode = 1;
    run_until_idle("rand_drain", 1000);
    check("byte_count", tx_count, gen_bytes + m_grants);
    check("wd_seen", n_wd > 0, 1'b1);

    // Watchdog: req 1 stalls after a non-last byte, req 3 shows up meanwhile.
    ready_mode = 0;
    gap_override = 20;
    push_byte(1, 8'h55, 0); push_byte(1, 8'h56, 1);
    push_byte(3, 8'h77, 1);
    gap_wait[3] = 5;
    n = 0;
    while (timeout_pulse !== 1'b1 && n < 40) begin cycle(); n++; end
    check("wd_pulse", timeout_pulse, 1'b1);
    check("wd_id", timeout_id, 2'd1);
    cycle();
    check("wd_next_grant", grant, 4'b1000);
    check("wd_pulse_one_cycle", timeout_pulse, 1'b0);
    run_until_idle("wd_drain", 200);

    // Asynchronous reset while req 1 waits between payload bytes.
    gap_override = 3;
    push_byte(1, 8'hA1, 0); push_byte(1, 8'hA2, 0); push_byte(1, 8'hA3, 1);
    n = 0;
    while (!(m_phase == 2 && q_data[1].size() == 2) && n < 40) begin cycle(); n++; end
    cycle();
    check("pre_rst_grant", grant, 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("arst_grant", grant, 4'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_req_ready", req_ready, 4'b0);
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      q_data[i].delete(); q_last[i].delete(); gap_wait[i] = 0; accepted[i] = 0;
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    gap_override = 0;
    push_byte(0, 8'h5A, 1); push_byte(1, 8'h6B, 1);
    cycle();
    cycle();
    check("rst_prio", grant, 4'b0001);
    run_until_idle("post_rst_drain", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
